// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port register file with a per-register busy scoreboard for the
//   decode/issue stage.
//   CLK       in   clock, rising edge
//   RESET     in   asynchronous active-low reset
//   RD_ADDR   in   NUM_RD read addresses, port k = [k*ADD_WIDTH +: ADD_WIDTH]
//   RD_DATA   out  NUM_RD read data (combinational, with write bypass)
//   RD_BUSY   out  NUM_RD busy flags (pending producer, masked by same-cycle write)
//   WR_EN     in   NUM_WR write enables
//   WR_ADDR   in   NUM_WR write addresses
//   WR_DATA   in   NUM_WR write data
//   RSV_EN    in   reserve RSV_ADDR (mark busy)
//   RSV_ADDR  in   register to reserve
//   BUSY_CNT  out  registered count of busy registers
module register_file_mp #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADD_WIDTH = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_RD*ADD_WIDTH-1:0] RD_ADDR,
  output logic [NUM_RD*WIDTH-1:0]     RD_DATA,
  output logic [NUM_RD-1:0]           RD_BUSY,
  input  logic [NUM_WR-1:0]           WR_EN,
  input  logic [NUM_WR*ADD_WIDTH-1:0] WR_ADDR,
  input  logic [NUM_WR*WIDTH-1:0]     WR_DATA,
  input  logic                        RSV_EN,
  input  logic [ADD_WIDTH-1:0]        RSV_ADDR,
  output logic [ADD_WIDTH:0]          BUSY_CNT
);

  localparam int unsigned DEPTH = 2**ADD_WIDTH;

  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [ADD_WIDTH:0]   cnt_q, cnt_d;
  logic [NUM_WR-1:0]    wr_ok;

  function automatic logic is_zero(input logic [ADD_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Enabled writes that actually land; writes to the hardwired zero register
  // are dropped here so neither storage, bypass nor scoreboard sees them.
  always_comb begin
    wr_ok = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = WR_EN[j] && !is_zero(WR_ADDR[j*ADD_WIDTH +: ADD_WIDTH]);
    end
  end

  // Scoreboard next state: clears from write-back first, reservation last so
  // a same-cycle reserve+write leaves the register busy for the new producer.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) begin
        busy_d[WR_ADDR[j*ADD_WIDTH +: ADD_WIDTH]] = 1'b0;
      end
    end
    if (RSV_EN && !is_zero(RSV_ADDR)) begin
      busy_d[RSV_ADDR] = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADD_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  // Storage: later write ports are applied last, so the higher index wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          regs_q[WR_ADDR[j*ADD_WIDTH +: ADD_WIDTH]] <= WR_DATA[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BUSY_CNT = cnt_q;

  // Read ports: stored value, overridden by the highest-index matching write.
  // Outputs are forced to zero while reset is held so a write presented
  // during reset cannot leak through the bypass.
  always_comb begin
    RD_DATA = '0;
    RD_BUSY = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      RD_DATA[k*WIDTH +: WIDTH] = regs_q[RD_ADDR[k*ADD_WIDTH +: ADD_WIDTH]];
      RD_BUSY[k]                = busy_q[RD_ADDR[k*ADD_WIDTH +: ADD_WIDTH]];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] &&
            (WR_ADDR[j*ADD_WIDTH +: ADD_WIDTH] == RD_ADDR[k*ADD_WIDTH +: ADD_WIDTH])) begin
          RD_DATA[k*WIDTH +: WIDTH] = WR_DATA[j*WIDTH +: WIDTH];
          RD_BUSY[k]                = 1'b0;
        end
      end
      if (is_zero(RD_ADDR[k*ADD_WIDTH +: ADD_WIDTH]) || !RESET) begin
        RD_DATA[k*WIDTH +: WIDTH] = '0;
        RD_BUSY[k]                = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Self-checking bench for register_file_mp (2 read ports, 2 write ports,
//   zero register enabled): directed vector table, reset corner cases and a
//   randomized run against a behavioural model.
module tb_register_file_mp;

  logic        CLK;
  logic        RESET;
  logic [9:0]  RD_ADDR;
  logic [63:0] RD_DATA;
  logic [1:0]  RD_BUSY;
  logic [1:0]  WR_EN;
  logic [9:0]  WR_ADDR;
  logic [63:0] WR_DATA;
  logic        RSV_EN;
  logic [4:0]  RSV_ADDR;
  logic [5:0]  BUSY_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  register_file_mp #(
    .WIDTH    (32),
    .ADD_WIDTH(5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA),
    .RD_BUSY (RD_BUSY),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .RSV_EN  (RSV_EN),
    .RSV_ADDR(RSV_ADDR),
    .BUSY_CNT(BUSY_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: plain register array plus a busy bit-vector.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  function automatic logic [4:0] wa(input int j);
    return (j == 0) ? WR_ADDR[4:0] : WR_ADDR[9:5];
  endfunction

  function automatic logic [31:0] wd(input int j);
    return (j == 0) ? WR_DATA[31:0] : WR_DATA[63:32];
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return '0;
    r = m_mem[a];
    for (int j = 1; j >= 0; j--) begin
      if (WR_EN[j] && wa(j) == a) return wd(j);
    end
    return r;
  endfunction

  function automatic logic m_bz(input logic [4:0] a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (WR_EN[j] && wa(j) == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  task automatic m_clock();
    for (int j = 0; j < 2; j++) begin
      if (WR_EN[j] && wa(j) != 0) begin
        m_mem[wa(j)]  = wd(j);
        m_busy[wa(j)] = 1'b0;
      end
    end
    if (RSV_EN && RSV_ADDR != 0) m_busy[RSV_ADDR] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic rsv,
                       input logic [4:0] ra, input logic [4:0] r0, input logic [4:0] r1);
    WR_EN    = we;
    WR_ADDR  = {a1, a0};
    WR_DATA  = {d1, d0};
    RSV_EN   = rsv;
    RSV_ADDR = ra;
    RD_ADDR  = {r1, r0};
  endtask

  task automatic model_checks();
    chk("rd_data0", RD_DATA[31:0],  m_rd(RD_ADDR[4:0]));
    chk("rd_data1", RD_DATA[63:32], m_rd(RD_ADDR[9:5]));
    chk("rd_busy",  RD_BUSY, {m_bz(RD_ADDR[9:5]), m_bz(RD_ADDR[4:0])});
  endtask

  // Asynchronous reset pulse fully between clock edges; effects must be immediate.
  task automatic pulse_reset();
    @(negedge CLK);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
    #1 RESET = 1'b0;
    #1;
    chk("rst_busy_cnt", BUSY_CNT, 0);
    chk("rst_rd_busy",  RD_BUSY, 2'b00);
    chk("rst_rd_data",  RD_DATA, 64'h0);
    #1 RESET = 1'b1;
    m_reset();
    #1;
    chk("post_rst_data", RD_DATA, 64'h0);
    chk("post_rst_busy", RD_BUSY, 2'b00);
    @(posedge CLK);
    m_clock();
    #1 chk("post_rst_cnt", BUSY_CNT, 0);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    // we    wa0 wd0            wa1 wd1      rsv ra  r0  r1  d0             d1             b      cnt
    vecs[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0,  5'd31, 32'h0,        32'h0,        2'b00, 6'd0};
    vecs[1]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
    vecs[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
    vecs[3]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 6'd0};
    vecs[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 6'd0};
    vecs[5]  = '{2'b01, 5'd0, 32'h55,       5'd0, 32'h0,  1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  5'd3,  32'h0,        32'h0,        2'b00, 6'd1};
    vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd7,  32'h0,        32'h22,       2'b01, 6'd1};
    vecs[9]  = '{2'b01, 5'd3, 32'h9,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd3,  32'h9,        32'h9,        2'b00, 6'd0};
    vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd3,  32'h9,        32'h9,        2'b00, 6'd0};
    vecs[11] = '{2'b01, 5'd3, 32'h9,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  5'd3,  32'h9,        32'h9,        2'b00, 6'd1};
    vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd3,  32'h9,        32'h9,        2'b11, 6'd1};
    vecs[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  5'd3,  32'h9,        32'h9,        2'b11, 6'd1};
    vecs[14] = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h77, 1'b1, 5'd4, 5'd3,  5'd4,  32'h77,       32'h0,        2'b00, 6'd1};
    vecs[15] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd1, 5'd4,  5'd3,  32'h0,        32'h77,       2'b01, 6'd2};
    vecs[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd2, 5'd1,  5'd2,  32'h0,        32'h0,        2'b01, 6'd3};

    RESET = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    m_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("in_rst_cnt",  BUSY_CNT, 0);
    chk("in_rst_data", RD_DATA, 64'h0);
    chk("in_rst_busy", RD_BUSY, 2'b00);
    @(negedge CLK);
    RESET = 1'b1;

    // Every address reads zero, not busy, after reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      RD_ADDR = {5'(2*i + 1), 5'(2*i)};
      #2;
      chk("init_data", RD_DATA, 64'h0);
      chk("init_busy", RD_BUSY, 2'b00);
      chk("init_cnt",  BUSY_CNT, 0);
    end

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].rsv, vecs[i].ra, vecs[i].r0, vecs[i].r1);
      #2;
      chk($sformatf("vec%0d_d0", i),   RD_DATA[31:0],  vecs[i].d0);
      chk($sformatf("vec%0d_d1", i),   RD_DATA[63:32], vecs[i].d1);
      chk($sformatf("vec%0d_busy", i), RD_BUSY, vecs[i].b);
      @(posedge CLK);
      m_clock();
      #1 chk($sformatf("vec%0d_cnt", i), BUSY_CNT, vecs[i].cnt);
    end

    // Busy count is 3 here; reset between edges must clear it immediately.
    pulse_reset();

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      @(negedge CLK);
      drive(2'($urandom), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 9)),
            5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
      #2;
      model_checks();
      @(posedge CLK);
      m_clock();
      #1 chk("rand_cnt", BUSY_CNT, 64'($countones(m_busy)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
